apb_mem_slave_p: RTL
====================

// Module: apb_mem_slave_p
// PURPOSE
// - Parametrised APB memory slave.
// - Successor to the fixed-size APB slave: width, depth and wait states are configurable.
// - Adds byte addressing, alignment/range error reporting, transfer abort, and optional byte strobes.
// - Sits behind the APB bridge as a generic scratch RAM peripheral and as the standard DUT for the APB bench.
// PARAMETERS
// - ADDR_WIDTH   12    paddr width, byte address; must be >= log2(MEM_DEPTH)+log2(DATA_WIDTH/8)
// - DATA_WIDTH   32    pwdata/prdata width; must be 8, 16, 32 or 64
// - MEM_DEPTH    1024  number of DATA_WIDTH-bit words
// - WAIT_STATES  0     pready-low cycles inserted in each access phase, 0..15
// PORTS
// - pclk     in   1             APB clock, all logic on rising edge
// - presetn  in   1             asynchronous active-low reset
// - psel     in   1             slave select
// - penable  in   1             access phase strobe
// - pwrite   in   1             1=write, 0=read
// - paddr    in   ADDR_WIDTH    byte address
// - pwdata   in   DATA_WIDTH    write data
// - pstrb    in   DATA_WIDTH/8  byte lane strobes (used only with APB_SLV_STRB_EN)
// - prdata   out  DATA_WIDTH    read data, valid while pready=1 on a read
// - pready   out  1             transfer completes on the edge where psel&penable&pready
// - pslverr  out  1             error flag, valid only while pready=1
// BEHAVIOUR
// - Reset (async, presetn=0): state=IDLE, wait counter=0, prdata=0, pready=0, pslverr=0.
// - Memory array is not reset; contents are undefined until written.
// - Word index = paddr >> log2(DATA_WIDTH/8).
// - Error condition: misaligned (paddr low log2(DATA_WIDTH/8) bits != 0) OR word index >= MEM_DEPTH.
// - FSM states: IDLE, WAIT, READY. All outputs are registered.
// - IDLE:
//     - psel=1 & penable=0 (setup) -> WAIT with cnt=WAIT_STATES-1 if WAIT_STATES>0, else -> READY.
//     - Protocol fault (penable=1 without a prior setup phase): ignored, stay IDLE.
// - WAIT:
//     - pready=0.
//     - If psel=1: decrement cnt; at cnt=0 -> READY.
//     - If psel=0 (abort): -> IDLE, no memory write, prdata unchanged.
// - READY:
//     - pready=1 and pslverr=error; both set on the edge entering READY.
//     - On that same edge, prdata is loaded with mem[index] (read, no error) or 0 (read with error).
//     - prdata is unchanged on writes.
//     - Completing edge (psel&penable): write without error commits pwdata to mem[index]; -> IDLE.
//     - Error write: no memory change.
//     - psel=0 while in READY: abort, no write, -> IDLE.
// - pready and pslverr return to 0 in the cycle after completion.
// - Transfer latency = 2+WAIT_STATES cycles (setup + access); back-to-back transfers need no extra idle cycle.
// - prdata holds its last read value between transfers.
// - Reset mid-transfer: immediate return to IDLE with reset outputs; an uncompleted write is never committed.
// - paddr, pwrite, pwdata and pstrb are sampled on the completing edge (write) or on the READY-entry edge (read).
//   The master must hold them stable from setup onward.
// CONFIGURATION
// - APB_SLV_STRB_EN defined: on a write, only byte lanes with pstrb[i]=1 are updated; other lanes keep old data.
//   pstrb=0 on a write completes normally with no memory change.
// - APB_SLV_STRB_EN undefined: pstrb is ignored and every write updates the full word.
// - Reads ignore pstrb in both builds.
// TESTING
// - Reset:
//     - presetn=0 during the access phase of a write of 0xA5A5A5A5 to 0x020.
//     - -> prdata=0, pready=0, pslverr=0 immediately.
//     - A later read of 0x020 returns the prior value, not 0xA5A5A5A5.
// - Basic, WAIT_STATES=0:
//     - Write 0xDEADBEEF to 0x010, then read 0x010.
//     - -> pready=1 in the 2nd cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
// - Wait states, WAIT_STATES=3:
//     - Read 0x004.
//     - -> pready low for 3 access cycles, high on the 4th; total 5 cycles.
//     - Back-to-back second read also takes 5 cycles.
// - Errors:
//     - Write to 0x013 (misaligned) -> pslverr=1 with pready, mem[4] unchanged.
//     - MEM_DEPTH=512, read 0x800 -> pslverr=1, prdata=0.
// - Strobes:
//     - Write 0xFFFFFFFF to 0x000, then 0x11223344 with pstrb=4'b0101, then read 0x000.
//     - -> 0xFF22FF44 with APB_SLV_STRB_EN; 0x11223344 without.
// - Abort:
//     - WAIT_STATES=2, write 0x12345678 to 0x030, psel dropped in the 1st wait cycle.
//     - -> FSM returns to IDLE, pready never asserted, mem[12] unchanged.

Source files
------------

// File: rtl/apb_mem_slave_p.sv
// Parametrised APB scratch-RAM slave with configurable width, depth and wait states.
// Define APB_SLV_STRB_EN to honour pstrb byte lanes on writes; otherwise writes update the full word.
module apb_mem_slave_p #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [3:0]              cnt_r, cnt_s;
    logic [DATA_WIDTH-1:0]   prdata_r, prdata_s;
    logic                    pready_r, pready_s;
    logic                    pslverr_r, pslverr_s;
    logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0]   idx_s;
    logic [IDX_W-1:0]        midx_s;
    logic                    err_s;
    logic                    we_s;
    logic [BYTES-1:0]        strb_s;
    logic [DATA_WIDTH-1:0]   rword_s, wdata_s, rd_load_s;

    // Replace only the byte lanes selected by strb; the rest keep the stored word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BYTES-1:0]      strb
    );
        logic [DATA_WIDTH-1:0] res;
        for (int i = 0; i < BYTES; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

`ifdef APB_SLV_STRB_EN
    assign strb_s = pstrb;
`else
    // Strobes ignored: every lane forced on.
    assign strb_s = pstrb | {BYTES{1'b1}};
`endif

    assign idx_s     = paddr >> LSB;
    assign midx_s    = idx_s[IDX_W-1:0];
    assign err_s     = (|(paddr & ALIGN_MASK)) || (32'(idx_s) >= 32'(MEM_DEPTH));
    assign rword_s   = mem_r[midx_s];
    assign wdata_s   = merge_lanes(rword_s, pwdata, strb_s);
    assign rd_load_s = pwrite ? prdata_r : (err_s ? {DATA_WIDTH{1'b0}} : rword_s);

    // Next-state, wait counter, registered-output and write-enable decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        prdata_s  = prdata_r;
        pready_s  = pready_r;
        pslverr_s = pslverr_r;
        we_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pready_s  = 1'b0;
                pslverr_s = 1'b0;
                if (psel && !penable) begin
                    if (WAIT_STATES > 0) begin
                        state_s = ST_WAIT;
                        cnt_s   = CNT_INIT;
                    end else begin
                        state_s   = ST_READY;
                        pready_s  = 1'b1;
                        pslverr_s = err_s;
                        prdata_s  = rd_load_s;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == 4'd0) begin
                    state_s   = ST_READY;
                    pready_s  = 1'b1;
                    pslverr_s = err_s;
                    prdata_s  = rd_load_s;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_READY: begin
                if (!psel) begin
                    state_s   = ST_IDLE;
                    pready_s  = 1'b0;
                    pslverr_s = 1'b0;
                end else if (penable) begin
                    we_s      = pwrite && !err_s;
                    state_s   = ST_IDLE;
                    pready_s  = 1'b0;
                    pslverr_s = 1'b0;
                end else begin
                    state_s = ST_READY;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                pready_s  = 1'b0;
                pslverr_s = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            prdata_r  <= {DATA_WIDTH{1'b0}};
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            prdata_r  <= prdata_s;
            pready_r  <= pready_s;
            pslverr_r <= pslverr_s;
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge pclk) begin
        if (we_s) begin
            mem_r[midx_s] <= wdata_s;
        end
    end

    assign prdata  = prdata_r;
    assign pready  = pready_r;
    assign pslverr = pslverr_r;

endmodule
